// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, NOP encoding and per-instruction hazard info for pipe_ctrl.
package pipe_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] SYSTEM = 7'b1110011;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

    localparam logic PC_SEL_PC4 = 1'b0;
    localparam logic PC_SEL_ALU = 1'b1;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             rs1_used;
        logic             rs2_used;
        logic             rd_written;
        logic             is_load;
        logic             is_jump;
        logic             is_branch;
    } hz_info_t;

endpackage

// File: rtl/pipe_ctrl_hazard_decode.sv
// Register-usage decode of one RV32I instruction for hazard detection.
module hazard_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [XLEN-1:0]  inst,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2,
    output logic [REG_W-1:0] rd,
    output logic             rs1_used,
    output logic             rs2_used,
    output logic             rd_written,
    output logic             is_load,
    output logic             is_jump,
    output logic             is_branch
);

    logic [OPC_W-1:0] opcode;
    logic             writes_rd;
    logic             unused_fields;

    assign opcode        = inst[6:0];
    assign rs1           = inst[19:15];
    assign rs2           = inst[24:20];
    assign rd            = inst[11:7];
    assign unused_fields = ^{inst[31:25], inst[14:12]};

    always_comb begin
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        is_jump   = 1'b0;
        is_branch = 1'b0;
        unique case (opcode)
            OP:     begin rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1; end
            OP_IMM: begin rs1_used = 1'b1; writes_rd = 1'b1; end
            LOAD:   begin rs1_used = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
            STORE:  begin rs1_used = 1'b1; rs2_used = 1'b1; end
            BRANCH: begin rs1_used = 1'b1; rs2_used = 1'b1; is_branch = 1'b1; end
            JALR:   begin rs1_used = 1'b1; writes_rd = 1'b1; is_jump = 1'b1; end
            JAL:    begin writes_rd = 1'b1; is_jump = 1'b1; end
            LUI, AUIPC, SYSTEM: writes_rd = 1'b1;
            default: ;
        endcase
    end

    // x0 is never a real destination
    assign rd_written = writes_rd & (rd != REG_W'(0));

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the D/X/WF pipeline; owns the X and WF instruction registers.
// PIPE_FWD_EN enables WF->X/D forwarding (only load-use stalls); otherwise RAW hazards stall.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_ENC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] inst_d,
    input  logic            br_taken_x,
    input  logic            stall_ext,
    output logic            pc_hold,
    output logic            pc_sel,
    output logic            nop_sel,
    output logic [XLEN-1:0] inst_x,
    output logic [XLEN-1:0] inst_wf,
    output logic            fwd_x_a,
    output logic            fwd_x_b,
    output logic            fwd_d_a,
    output logic            fwd_d_b,
    output logic            rf_we_wf
);

    hz_info_t hz_d;
    hz_info_t hz_x;
    hz_info_t hz_wf;
    logic     boot_q;
    logic     redirect;
    logic     data_stall;
    logic     d_rs1_x, d_rs2_x, d_rs1_wf, d_rs2_wf;
    logic     unused_hz;

    hazard_decode u_dec_d (
        .inst(inst_d), .rs1(hz_d.rs1), .rs2(hz_d.rs2), .rd(hz_d.rd),
        .rs1_used(hz_d.rs1_used), .rs2_used(hz_d.rs2_used), .rd_written(hz_d.rd_written),
        .is_load(hz_d.is_load), .is_jump(hz_d.is_jump), .is_branch(hz_d.is_branch)
    );

    hazard_decode u_dec_x (
        .inst(inst_x), .rs1(hz_x.rs1), .rs2(hz_x.rs2), .rd(hz_x.rd),
        .rs1_used(hz_x.rs1_used), .rs2_used(hz_x.rs2_used), .rd_written(hz_x.rd_written),
        .is_load(hz_x.is_load), .is_jump(hz_x.is_jump), .is_branch(hz_x.is_branch)
    );

    hazard_decode u_dec_wf (
        .inst(inst_wf), .rs1(hz_wf.rs1), .rs2(hz_wf.rs2), .rd(hz_wf.rd),
        .rs1_used(hz_wf.rs1_used), .rs2_used(hz_wf.rs2_used), .rd_written(hz_wf.rd_written),
        .is_load(hz_wf.is_load), .is_jump(hz_wf.is_jump), .is_branch(hz_wf.is_branch)
    );

    assign unused_hz = ^{hz_d, hz_x, hz_wf};

    // D source operands against the X and WF destinations
    assign d_rs1_x  = hz_d.rs1_used & hz_x.rd_written  & (hz_d.rs1 == hz_x.rd);
    assign d_rs2_x  = hz_d.rs2_used & hz_x.rd_written  & (hz_d.rs2 == hz_x.rd);
    assign d_rs1_wf = hz_d.rs1_used & hz_wf.rd_written & (hz_d.rs1 == hz_wf.rd);
    assign d_rs2_wf = hz_d.rs2_used & hz_wf.rd_written & (hz_d.rs2 == hz_wf.rd);

    assign redirect = hz_x.is_jump | (hz_x.is_branch & br_taken_x);

`ifdef PIPE_FWD_EN
    assign data_stall = hz_x.is_load & (d_rs1_x | d_rs2_x);
    assign fwd_x_a    = hz_x.rs1_used & hz_wf.rd_written & (hz_x.rs1 == hz_wf.rd);
    assign fwd_x_b    = hz_x.rs2_used & hz_wf.rd_written & (hz_x.rs2 == hz_wf.rd);
    assign fwd_d_a    = d_rs1_wf;
    assign fwd_d_b    = d_rs2_wf;
`else
    assign data_stall = d_rs1_x | d_rs2_x | d_rs1_wf | d_rs2_wf;
    assign fwd_x_a    = 1'b0;
    assign fwd_x_b    = 1'b0;
    assign fwd_d_a    = 1'b0;
    assign fwd_d_b    = 1'b0;
`endif

    // Priority: external freeze > redirect > data stall > advance
    always_comb begin
        pc_hold  = 1'b0;
        pc_sel   = PC_SEL_PC4;
        nop_sel  = boot_q;
        rf_we_wf = hz_wf.rd_written;
        if (stall_ext) begin
            pc_hold  = 1'b1;
            nop_sel  = 1'b0;
            rf_we_wf = 1'b0;
        end else if (redirect) begin
            pc_sel  = PC_SEL_ALU;
            nop_sel = 1'b1;
        end else if (data_stall) begin
            pc_hold = 1'b1;
            nop_sel = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_x  <= NOP_INST;
            inst_wf <= NOP_INST;
            boot_q  <= 1'b1;
        end else if (!stall_ext) begin
            inst_wf <= inst_x;
            inst_x  <= nop_sel ? NOP_INST : inst_d;
            boot_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with an expected-pipeline-contents scoreboard.
module tb_pipe_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] I_A  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_B  = 32'h0010_8133; // add  x2,x1,x1
    localparam logic [31:0] I_C  = 32'h0020_82B3; // add  x5,x1,x2
    localparam logic [31:0] I_L  = 32'h0000_2183; // lw   x3,0(x0)
    localparam logic [31:0] I_U  = 32'h0011_8213; // addi x4,x3,1
    localparam logic [31:0] I_Q  = 32'h0000_0463; // beq  x0,x0,8
    localparam logic [31:0] I_J  = 32'h0100_00EF; // jal  x1,16

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_d;
    logic        br_taken_x;
    logic        stall_ext;
    logic        pc_hold, pc_sel, nop_sel;
    logic [31:0] inst_x, inst_wf;
    logic        fwd_x_a, fwd_x_b, fwd_d_a, fwd_d_b;
    logic        rf_we_wf;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_x, exp_wf;

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .br_taken_x(br_taken_x),
        .stall_ext(stall_ext), .pc_hold(pc_hold), .pc_sel(pc_sel), .nop_sel(nop_sel),
        .inst_x(inst_x), .inst_wf(inst_wf), .fwd_x_a(fwd_x_a), .fwd_x_b(fwd_x_b),
        .fwd_d_a(fwd_d_a), .fwd_d_b(fwd_d_b), .rf_we_wf(rf_we_wf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish within 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at posedge+1, check combinational outputs mid-cycle,
    // push expected next X/WF contents, then compare them after the edge.
    task automatic step(input string nm, input logic [31:0] d, input logic br, input logic sx,
                        input logic [2:0] e_hsn, input logic [3:0] e_fwd, input logic e_we);
        logic [63:0] e;
        inst_d     = d;
        br_taken_x = br;
        stall_ext  = sx;
        #4;
        chk($sformatf("%s.pc_hold", nm), 32'(pc_hold), 32'(e_hsn[2]));
        chk($sformatf("%s.pc_sel", nm), 32'(pc_sel), 32'(e_hsn[1]));
        chk($sformatf("%s.nop_sel", nm), 32'(nop_sel), 32'(e_hsn[0]));
        chk($sformatf("%s.fwd", nm), 32'({fwd_x_a, fwd_x_b, fwd_d_a, fwd_d_b}), 32'(e_fwd));
        chk($sformatf("%s.rf_we_wf", nm), 32'(rf_we_wf), 32'(e_we));
        if (sx) sb_q.push_back({exp_x, exp_wf});
        else    sb_q.push_back({(e_hsn[0] ? NOP : d), exp_x});
        @(posedge clk);
        #1;
        e      = sb_q.pop_front();
        exp_x  = e[63:32];
        exp_wf = e[31:0];
        chk($sformatf("%s.inst_x", nm), inst_x, exp_x);
        chk($sformatf("%s.inst_wf", nm), inst_wf, exp_wf);
    endtask

    task automatic chk_reset(input string nm);
        chk($sformatf("%s.inst_x", nm), inst_x, NOP);
        chk($sformatf("%s.inst_wf", nm), inst_wf, NOP);
        chk($sformatf("%s.pc_hold", nm), 32'(pc_hold), 32'(0));
        chk($sformatf("%s.pc_sel", nm), 32'(pc_sel), 32'(0));
        chk($sformatf("%s.nop_sel", nm), 32'(nop_sel), 32'(1));
        chk($sformatf("%s.fwd", nm), 32'({fwd_x_a, fwd_x_b, fwd_d_a, fwd_d_b}), 32'(0));
        chk($sformatf("%s.rf_we_wf", nm), 32'(rf_we_wf), 32'(0));
    endtask

    initial begin
        rst_n = 1'b1; inst_d = NOP; br_taken_x = 1'b0; stall_ext = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        exp_x = NOP; exp_wf = NOP;

        // boot bubble, then ALU producer/consumer
        step("boot", NOP, 0, 0, 3'b001, 4'b0000, 0);
        step("s2",   I_A, 0, 0, 3'b000, 4'b0000, 0);
`ifdef PIPE_FWD_EN
        step("s3",   I_B, 0, 0, 3'b000, 4'b0000, 0);
        step("s4",   NOP, 0, 0, 3'b000, 4'b1100, 1);
        step("s5",   I_A, 0, 0, 3'b000, 4'b0000, 1);
        step("s6",   NOP, 0, 0, 3'b000, 4'b0000, 0);
        step("s7",   I_B, 0, 0, 3'b000, 4'b0011, 1);
        step("s8",   NOP, 0, 0, 3'b000, 4'b0000, 0);
        step("s9",   NOP, 0, 0, 3'b000, 4'b0000, 1);
`else
        step("s3",   I_B, 0, 0, 3'b101, 4'b0000, 0);
        step("s4",   I_B, 0, 0, 3'b101, 4'b0000, 1);
        step("s5",   I_B, 0, 0, 3'b000, 4'b0000, 0);
        step("s6",   NOP, 0, 0, 3'b000, 4'b0000, 0);
        step("s7",   NOP, 0, 0, 3'b000, 4'b0000, 1);
`endif

        // load-use
        step("l1",   I_L, 0, 0, 3'b000, 4'b0000, 0);
`ifdef PIPE_FWD_EN
        step("l2",   I_U, 0, 0, 3'b101, 4'b0000, 0);
        step("l3",   I_U, 0, 0, 3'b000, 4'b0010, 1);
        step("l4",   NOP, 0, 0, 3'b000, 4'b0000, 0);
        step("l5",   NOP, 0, 0, 3'b000, 4'b0000, 1);
`else
        step("l2",   I_U, 0, 0, 3'b101, 4'b0000, 0);
        step("l3",   I_U, 0, 0, 3'b101, 4'b0000, 1);
        step("l4",   I_U, 0, 0, 3'b000, 4'b0000, 0);
        step("l5",   NOP, 0, 0, 3'b000, 4'b0000, 0);
        step("l6",   NOP, 0, 0, 3'b000, 4'b0000, 1);
`endif

        // taken then not-taken branch
        step("b1",   I_Q, 0, 0, 3'b000, 4'b0000, 0);
        step("b2",   I_A, 1, 0, 3'b011, 4'b0000, 0);
        step("b3",   NOP, 0, 0, 3'b000, 4'b0000, 0);
        step("b4",   I_Q, 0, 0, 3'b000, 4'b0000, 0);
        step("b5",   I_A, 0, 0, 3'b000, 4'b0000, 0);
        step("b6",   NOP, 0, 0, 3'b000, 4'b0000, 0);
        step("b7",   NOP, 0, 0, 3'b000, 4'b0000, 1);

        // jal beats a dependent D instruction; back-to-back jumps
        step("j1",   I_J, 0, 0, 3'b000, 4'b0000, 0);
        step("j2",   I_B, 0, 0, 3'b011, 4'b0000, 0);
        step("j3",   I_J, 0, 0, 3'b000, 4'b0000, 1);
        step("j4",   I_A, 0, 0, 3'b011, 4'b0000, 0);
        step("j5",   NOP, 0, 0, 3'b000, 4'b0000, 1);

        // external freeze with a writer in WF, then freeze over a taken branch
        step("e1",   I_C, 0, 0, 3'b000, 4'b0000, 0);
        step("e2",   I_A, 0, 0, 3'b000, 4'b0000, 0);
        step("e3",   NOP, 0, 1, 3'b100, 4'b0000, 0);
        step("e4",   NOP, 0, 1, 3'b100, 4'b0000, 0);
        step("e5",   NOP, 0, 1, 3'b100, 4'b0000, 0);
        step("e6",   NOP, 0, 0, 3'b000, 4'b0000, 1);
        step("e7",   NOP, 0, 0, 3'b000, 4'b0000, 1);
        step("e8",   I_Q, 0, 0, 3'b000, 4'b0000, 0);
        step("e9",   I_A, 1, 1, 3'b100, 4'b0000, 0);
        step("e10",  I_A, 1, 0, 3'b011, 4'b0000, 0);
        step("e11",  NOP, 0, 0, 3'b000, 4'b0000, 0);

        // reset in the middle of a flush; boot flag survives a stall at release
        step("r1",   I_Q, 0, 0, 3'b000, 4'b0000, 0);
        inst_d = I_A; br_taken_x = 1'b1; stall_ext = 1'b0;
        #2;
        chk("r2.pc_sel", 32'(pc_sel), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_reset("r2rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        br_taken_x = 1'b0;
        exp_x = NOP; exp_wf = NOP;
        step("rb0",  I_A, 0, 1, 3'b100, 4'b0000, 0);
        step("rb1",  I_A, 0, 0, 3'b001, 4'b0000, 0);
        step("rb2",  I_A, 0, 0, 3'b000, 4'b0000, 0);
        step("rb3",  NOP, 0, 0, 3'b000, 4'b0000, 0);
        step("rb4",  NOP, 0, 0, 3'b000, 4'b0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
